pdp_mem_responder: RTL

- Single-port 4096x12 PDP-8 memory that serves three requesters on one array: ifu read, exec read and exec write.
- It is the responder end of the ifu/exec memory request interface. Each request is buffered, arbitrated to one array access per cycle, and answered with a valid-qualified read-data pulse.
- Sits between instr_decode/instr_exec and the storage array. Also provides a loader port for test benches to preload the image.

---
 rtl/pdp8_pkg.sv | 38 +++
 rtl/pdp_mem_arbiter.sv | 51 +++++
 rtl/pdp_mem_responder.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/pdp8_pkg.sv
// Shared types for the PDP-8 memory responder: grant encoding, pending-slot
// records and the default ifu starvation limit.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 12
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 12
`endif

package pdp8_pkg;

  localparam int AW           = `ADDR_WIDTH;
  localparam int DW           = `DATA_WIDTH;
  localparam int MAX_WAIT_DEF = 3;

  // Which requester owns the single array port this cycle.
  typedef enum logic [2:0] {
    GNT_NONE,
    GNT_LD,
    GNT_IFU,
    GNT_EXWR,
    GNT_EXRD
  } gnt_e;

  // Pending request record; data is only meaningful for the write slot.
  typedef struct packed {
    logic          valid;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } slot_t;

  // Read requesters carry no payload, so their slot drops the data field.
  typedef struct packed {
    logic          valid;
    logic [AW-1:0] addr;
  } rd_slot_t;

endpackage

// File: rtl/pdp_mem_arbiter.sv
// Fixed-priority arbiter for the shared memory port with an ifu starvation
// counter. Once the ifu has lost MAX_WAIT times in a row it jumps ahead of
// both exec requesters; only the loader can still pre-empt it.
module pdp_mem_arbiter
  import pdp8_pkg::*;
#(
  parameter int MAX_WAIT = MAX_WAIT_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic ld_en,
  input  logic ifu_cand,
  input  logic exwr_cand,
  input  logic exrd_cand,
  output gnt_e gnt
);

  localparam int CW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);

  logic [CW-1:0] wait_cnt;
  logic          ifu_forced;

  // Counter saturates so a long loader burst cannot wrap it back to zero.
  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    if (v >= CW'(MAX_WAIT)) return CW'(MAX_WAIT);
    return v + CW'(1);
  endfunction

  // Priority select: loader, starved ifu, exec write, exec read, ifu.
  always_comb begin
    gnt        = GNT_NONE;
    ifu_forced = ifu_cand && (wait_cnt == CW'(MAX_WAIT));
    if (ld_en)          gnt = GNT_LD;
    else if (ifu_forced) gnt = GNT_IFU;
    else if (exwr_cand) gnt = GNT_EXWR;
    else if (exrd_cand) gnt = GNT_EXRD;
    else if (ifu_cand)  gnt = GNT_IFU;
  end

  // Count consecutive cycles the ifu is waiting without being served.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt <= '0;
    end else if (gnt == GNT_IFU || !ifu_cand) begin
      wait_cnt <= '0;
    end else begin
      wait_cnt <= sat_inc(wait_cnt);
    end
  end

endmodule

// File: rtl/pdp_mem_responder.sv
// Single-port PDP-8 memory shared by ifu reads, exec reads and exec writes.
// Each requester has a one-deep pending slot; a fresh request is visible to
// the arbiter in the cycle it arrives, so an idle memory answers a read with
// one cycle of latency. Read data and done strobes are registered.
module pdp_mem_responder
  import pdp8_pkg::*;
#(
  parameter int ADDR_WIDTH = `ADDR_WIDTH,
  parameter int DATA_WIDTH = `DATA_WIDTH,
  parameter int MAX_WAIT   = MAX_WAIT_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ifu_rd_req,
  input  logic [ADDR_WIDTH-1:0] ifu_rd_addr,
  output logic [DATA_WIDTH-1:0] ifu_rd_data,
  output logic                  ifu_rd_valid,
  input  logic                  exec_rd_req,
  input  logic [ADDR_WIDTH-1:0] exec_rd_addr,
  output logic [DATA_WIDTH-1:0] exec_rd_data,
  output logic                  exec_rd_valid,
  input  logic                  exec_wr_req,
  input  logic [ADDR_WIDTH-1:0] exec_wr_addr,
  input  logic [DATA_WIDTH-1:0] exec_wr_data,
  output logic                  exec_wr_done,
  input  logic                  ld_en,
  input  logic [ADDR_WIDTH-1:0] ld_addr,
  input  logic [DATA_WIDTH-1:0] ld_data,
  output logic                  busy,
  output logic                  err_overrun
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  rd_slot_t ifu_slot;
  rd_slot_t exrd_slot;
  slot_t    exwr_slot;

  logic                  ifu_cand_p0;
  logic                  exrd_cand_p0;
  logic                  exwr_cand_p0;
  logic [ADDR_WIDTH-1:0] ifu_addr_p0;
  logic [ADDR_WIDTH-1:0] exrd_addr_p0;
  logic [ADDR_WIDTH-1:0] exwr_addr_p0;
  logic [DATA_WIDTH-1:0] exwr_data_p0;
  gnt_e                  gnt_p0;
  logic                  overrun_p0;

  // Next state of a read slot: a held request survives until granted; a
  // new request is only captured if it is not served on arrival.
  function automatic rd_slot_t rd_slot_next(input rd_slot_t s, input logic g,
                                            input logic req,
                                            input logic [ADDR_WIDTH-1:0] a);
    rd_slot_t n;
    n = '0;
    if (s.valid && !g) n = s;
    else if (req && (s.valid || !g)) n = '{valid: 1'b1, addr: a};
    return n;
  endfunction

  // Same rule for the write slot, which also carries the write data.
  function automatic slot_t wr_slot_next(input slot_t s, input logic g,
                                         input logic req,
                                         input logic [ADDR_WIDTH-1:0] a,
                                         input logic [DATA_WIDTH-1:0] d);
    slot_t n;
    n = '0;
    if (s.valid && !g) n = s;
    else if (req && (s.valid || !g)) n = '{valid: 1'b1, addr: a, data: d};
    return n;
  endfunction

  // ---- stage p0: candidate formation (held slot wins over a new request)
  always_comb begin
    ifu_cand_p0  = ifu_slot.valid  || ifu_rd_req;
    exrd_cand_p0 = exrd_slot.valid || exec_rd_req;
    exwr_cand_p0 = exwr_slot.valid || exec_wr_req;
    ifu_addr_p0  = ifu_slot.valid  ? ifu_slot.addr  : ifu_rd_addr;
    exrd_addr_p0 = exrd_slot.valid ? exrd_slot.addr : exec_rd_addr;
    exwr_addr_p0 = exwr_slot.valid ? exwr_slot.addr : exec_wr_addr;
    exwr_data_p0 = exwr_slot.valid ? exwr_slot.data : exec_wr_data;
  end

  pdp_mem_arbiter #(
    .MAX_WAIT (MAX_WAIT)
  ) u_arb (
    .clk       (clk),
    .reset     (reset),
    .ld_en     (ld_en),
    .ifu_cand  (ifu_cand_p0),
    .exwr_cand (exwr_cand_p0),
    .exrd_cand (exrd_cand_p0),
    .gnt       (gnt_p0)
  );

  // A request that hits a still-held, unserved slot is dropped and flagged.
  always_comb begin
    overrun_p0 = (ifu_rd_req  && ifu_slot.valid  && gnt_p0 != GNT_IFU)
              || (exec_rd_req && exrd_slot.valid && gnt_p0 != GNT_EXRD)
              || (exec_wr_req && exwr_slot.valid && gnt_p0 != GNT_EXWR);
  end

  assign busy = ifu_cand_p0 || exrd_cand_p0 || exwr_cand_p0;

  // Pending slots and the sticky overrun flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ifu_slot    <= '0;
      exrd_slot   <= '0;
      exwr_slot   <= '0;
      err_overrun <= 1'b0;
    end else begin
      ifu_slot    <= rd_slot_next(ifu_slot, gnt_p0 == GNT_IFU, ifu_rd_req, ifu_rd_addr);
      exrd_slot   <= rd_slot_next(exrd_slot, gnt_p0 == GNT_EXRD, exec_rd_req, exec_rd_addr);
      exwr_slot   <= wr_slot_next(exwr_slot, gnt_p0 == GNT_EXWR, exec_wr_req,
                                  exec_wr_addr, exec_wr_data);
      err_overrun <= err_overrun || overrun_p0;
    end
  end

  // Array write port; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (ld_en) begin
      mem[ld_addr] <= ld_data;
    end else if (!reset && gnt_p0 == GNT_EXWR) begin
      mem[exwr_addr_p0] <= exwr_data_p0;
    end
  end

  // ---- stage p1: registered responses; read data holds between pulses
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ifu_rd_valid  <= 1'b0;
      exec_rd_valid <= 1'b0;
      exec_wr_done  <= 1'b0;
      ifu_rd_data   <= '0;
      exec_rd_data  <= '0;
    end else begin
      ifu_rd_valid  <= (gnt_p0 == GNT_IFU);
      exec_rd_valid <= (gnt_p0 == GNT_EXRD);
      exec_wr_done  <= (gnt_p0 == GNT_EXWR);
      if (gnt_p0 == GNT_IFU)  ifu_rd_data  <= mem[ifu_addr_p0];
      if (gnt_p0 == GNT_EXRD) exec_rd_data <= mem[exrd_addr_p0];
    end
  end

endmodule
